// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multi-cycle controller and the RV32I datapath.
// master = controller side (drives selects/enables), slave = datapath side.
// Optional illegal_instr flag exists only when MCU_ILLEGAL_TRAP_EN is defined.
interface multicycle_control_unit_if #(
  parameter int ALUCTL_W   = 3,
  parameter int PERF_CNT_W = 32
);
  logic [31:0]           instr;
  logic                  zero_flg;
  logic                  mem_ready;
  logic                  PCWrite;
  logic                  AdrSrc;
  logic                  MemWrite;
  logic                  IRWrite;
  logic [1:0]            ResultSrc;
  logic [1:0]            ALUSrcA;
  logic [1:0]            ALUSrcB;
  logic [ALUCTL_W-1:0]   ALUControl;
  logic [1:0]            ImmSrc;
  logic                  RegWrite;
  logic                  instr_retired;
  logic [PERF_CNT_W-1:0] retired_cnt;
  logic [3:0]            state_o;
`ifdef MCU_ILLEGAL_TRAP_EN
  logic                  illegal_instr;

  modport master (
    input  instr, zero_flg, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, instr_retired, retired_cnt, state_o,
           illegal_instr
  );

  modport slave (
    output instr, zero_flg, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, instr_retired, retired_cnt, state_o,
           illegal_instr
  );
`else
  modport master (
    input  instr, zero_flg, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, instr_retired, retired_cnt, state_o
  );

  modport slave (
    output instr, zero_flg, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, instr_retired, retired_cnt, state_o
  );
`endif
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore multi-cycle RV32I controller: FETCH/DECODE/EXECUTE/MEM/WB sequencing plus retire counter.
// Latency (mem_ready=1): lw 5, sw/R/I/jal 4, beq 3 cycles; each mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE adds one.
// Stalls on mem_ready; MCU_ILLEGAL_TRAP_EN adds a sticky TRAP state and the illegal_instr flag.
module multicycle_control_unit #(
  parameter int ALUCTL_W      = 3,
  parameter int MEM_HANDSHAKE = 1,
  parameter int PERF_CNT_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  multicycle_control_unit_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
`ifdef MCU_ILLEGAL_TRAP_EN
    , S_TRAP   = 4'd11
`endif
  } state_t;

  // Per-state control word. need_rdy marks states whose enables/retire wait on mem_ready.
  typedef struct packed {
    logic       adr_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       ir_write;
    logic       pc_update;
    logic       branch;
    logic       mem_write;
    logic       reg_write;
    logic       retire;
    logic       need_rdy;
  } ctl_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [PERF_CNT_W-1:0] CNT_ONE = {{(PERF_CNT_W-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  ctl_t                  ctl_q;
  logic [PERF_CNT_W-1:0] retired_cnt_q;
  logic                  mem_rdy;
  logic                  step_ok;
  logic                  retire_pulse;
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [2:0]            alu3;
  logic [ALUCTL_W-1:0]   alu_ctl;
  logic [1:0]            imm_src;
  logic                  unused_instr_bits;

  assign opcode  = bus.instr[6:0];
  assign funct3  = bus.instr[14:12];
  assign mem_rdy = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;
  assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  // Control word for a given state; registered on state entry so selects are glitch-free.
  function automatic ctl_t ctl_of(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.src_b      = 2'b10;
        c.result_src = 2'b10;
        c.ir_write   = 1'b1;
        c.pc_update  = 1'b1;
        c.need_rdy   = 1'b1;
      end
      S_DECODE: begin
        c.src_a = 2'b01;
        c.src_b = 2'b01;
      end
      S_MEMADR: begin
        c.src_a = 2'b10;
        c.src_b = 2'b01;
      end
      S_MEMREAD: begin
        c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
        c.retire     = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
        c.retire    = 1'b1;
        c.need_rdy  = 1'b1;
      end
      S_EXECUTER: begin
        c.src_a  = 2'b10;
        c.src_b  = 2'b00;
        c.alu_op = 2'b10;
      end
      S_EXECUTEI: begin
        c.src_a  = 2'b10;
        c.src_b  = 2'b01;
        c.alu_op = 2'b10;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.retire    = 1'b1;
      end
      S_BEQ: begin
        c.src_a  = 2'b10;
        c.src_b  = 2'b00;
        c.alu_op = 2'b01;
        c.branch = 1'b1;
        c.retire = 1'b1;
      end
      S_JAL: begin
        c.src_a     = 2'b01;
        c.src_b     = 2'b10;
        c.pc_update = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state sequencing, including mem_ready stalls and opcode dispatch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
`ifdef MCU_ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_rdy) state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
`ifdef MCU_ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // FSM state and its registered control word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      ctl_q   <= ctl_of(S_FETCH);
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_of(state_d);
    end
  end

  // Retired-instruction counter; wraps naturally at full scale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt_q <= '0;
    end else if (retire_pulse) begin
      retired_cnt_q <= retired_cnt_q + CNT_ONE;
    end
  end

  // ALU operation decode from the registered ALUOp and the live instruction fields.
  always_comb begin
    alu3 = 3'b000;
    case (ctl_q.alu_op)
      2'b01: alu3 = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu3 = (opcode[5] & bus.instr[30]) ? 3'b001 : 3'b000;
          3'b010:  alu3 = 3'b101;
          3'b100:  alu3 = 3'b100;
          3'b110:  alu3 = 3'b011;
          3'b111:  alu3 = 3'b010;
          default: alu3 = 3'b000;
        endcase
      end
      default: alu3 = 3'b000;
    endcase
    alu_ctl      = '0;
    alu_ctl[2:0] = alu3;
  end

  // Immediate format from opcode alone.
  always_comb begin
    case (opcode)
      OP_STORE:  imm_src = 2'b01;
      OP_BRANCH: imm_src = 2'b10;
      OP_JAL:    imm_src = 2'b11;
      default:   imm_src = 2'b00;
    endcase
  end

  // Enables are gated by rst so they drop asynchronously, and by mem_ready in stalling states.
  assign step_ok      = ~ctl_q.need_rdy | mem_rdy;
  assign retire_pulse = ~rst & ctl_q.retire & step_ok;

  assign bus.PCWrite       = ~rst & ((ctl_q.pc_update & step_ok) | (ctl_q.branch & bus.zero_flg));
  assign bus.IRWrite       = ~rst & ctl_q.ir_write & mem_rdy;
  assign bus.MemWrite      = ~rst & ctl_q.mem_write;
  assign bus.RegWrite      = ~rst & ctl_q.reg_write;
  assign bus.instr_retired = retire_pulse;
  assign bus.AdrSrc        = ctl_q.adr_src;
  assign bus.ResultSrc     = ctl_q.result_src;
  assign bus.ALUSrcA       = ctl_q.src_a;
  assign bus.ALUSrcB       = ctl_q.src_b;
  assign bus.ALUControl    = alu_ctl;
  assign bus.ImmSrc        = imm_src;
  assign bus.retired_cnt   = retired_cnt_q;
  assign bus.state_o       = state_q;
`ifdef MCU_ILLEGAL_TRAP_EN
  assign bus.illegal_instr = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: state walk, selects, enables, latency, retire count.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
// Illegal-opcode expectations follow MCU_ILLEGAL_TRAP_EN.
module tb_multicycle_control_unit;

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_SUB = 32'h402081B3;
  localparam logic [31:0] I_LW  = 32'h0080A283;
  localparam logic [31:0] I_SW  = 32'h0020A023;
  localparam logic [31:0] I_BEQ = 32'h00208463;
  localparam logic [31:0] I_JAL = 32'h000000EF;
  localparam logic [31:0] I_ILL = 32'h0000007F;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   cyc;
  int   t0;

  multicycle_control_unit_if #(.ALUCTL_W(3), .PERF_CNT_W(32)) bus ();

  multicycle_control_unit #(
    .ALUCTL_W(3),
    .MEM_HANDSHAKE(1),
    .PERF_CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst           = 1'b1;
    bus.instr     = 32'h0;
    bus.zero_flg  = 1'b0;
    bus.mem_ready = 1'b1;
    step();
    step();

    // Reset state: enables forced low even with mem_ready high, FETCH selects
    check("rst_state",  32'(bus.state_o), 32'd0);
    check("rst_cnt",    bus.retired_cnt, 32'd0);
    check("rst_irw",    32'(bus.IRWrite), 32'd0);
    check("rst_pcw",    32'(bus.PCWrite), 32'd0);
    check("rst_memw",   32'(bus.MemWrite), 32'd0);
    check("rst_regw",   32'(bus.RegWrite), 32'd0);
    check("rst_ret",    32'(bus.instr_retired), 32'd0);
    check("rst_srcb",   32'(bus.ALUSrcB), 32'd2);
    check("rst_ressrc", 32'(bus.ResultSrc), 32'd2);
    rst = 1'b0;
    #1;
    check("fetch_irw",  32'(bus.IRWrite), 32'd1);
    check("fetch_pcw",  32'(bus.PCWrite), 32'd1);
    check("fetch_adr",  32'(bus.AdrSrc), 32'd0);

    // add: 0,1,6,8
    bus.instr = I_ADD;
    t0 = cyc;
    step();
    check("add_s1",     32'(bus.state_o), 32'd1);
    check("add_dec_a",  32'(bus.ALUSrcA), 32'd1);
    check("add_dec_b",  32'(bus.ALUSrcB), 32'd1);
    step();
    check("add_s6",     32'(bus.state_o), 32'd6);
    check("add_aluctl", 32'(bus.ALUControl), 32'd0);
    check("add_srca",   32'(bus.ALUSrcA), 32'd2);
    check("add_srcb",   32'(bus.ALUSrcB), 32'd0);
    step();
    check("add_s8",     32'(bus.state_o), 32'd8);
    check("add_regw",   32'(bus.RegWrite), 32'd1);
    check("add_ressrc", 32'(bus.ResultSrc), 32'd0);
    check("add_ret",    32'(bus.instr_retired), 32'd1);
    step();
    check("add_s0",     32'(bus.state_o), 32'd0);
    check("add_cnt",    bus.retired_cnt, 32'd1);
    check("add_cycles", 32'(cyc - t0), 32'd4);

    // sub with one FETCH stall cycle
    bus.instr     = I_SUB;
    bus.mem_ready = 1'b0;
    #1;
    check("stall_irw",  32'(bus.IRWrite), 32'd0);
    check("stall_pcw",  32'(bus.PCWrite), 32'd0);
    step();
    check("stall_s0",   32'(bus.state_o), 32'd0);
    bus.mem_ready = 1'b1;
    step();
    check("sub_s1",     32'(bus.state_o), 32'd1);
    step();
    check("sub_s6",     32'(bus.state_o), 32'd6);
    check("sub_aluctl", 32'(bus.ALUControl), 32'd1);
    step();
    step();
    check("sub_s0",     32'(bus.state_o), 32'd0);
    check("sub_cnt",    bus.retired_cnt, 32'd2);

    // lw with two MEMREAD wait cycles: 7 cycles
    bus.instr = I_LW;
    t0 = cyc;
    step();
    check("lw_imm",     32'(bus.ImmSrc), 32'd0);
    step();
    check("lw_s2",      32'(bus.state_o), 32'd2);
    step();
    check("lw_s3",      32'(bus.state_o), 32'd3);
    check("lw_adr",     32'(bus.AdrSrc), 32'd1);
    bus.mem_ready = 1'b0;
    step();
    check("lw_wait1",   32'(bus.state_o), 32'd3);
    step();
    check("lw_wait2",   32'(bus.state_o), 32'd3);
    bus.mem_ready = 1'b1;
    step();
    check("lw_s4",      32'(bus.state_o), 32'd4);
    check("lw_regw",    32'(bus.RegWrite), 32'd1);
    check("lw_ressrc",  32'(bus.ResultSrc), 32'd1);
    check("lw_ret",     32'(bus.instr_retired), 32'd1);
    step();
    check("lw_s0",      32'(bus.state_o), 32'd0);
    check("lw_cycles",  32'(cyc - t0), 32'd7);
    check("lw_cnt",     bus.retired_cnt, 32'd3);

    // beq taken then not taken: 3 cycles each
    bus.instr = I_BEQ;
    for (int z = 1; z >= 0; z--) begin
      bus.zero_flg = z[0];
      t0 = cyc;
      step();
      check("beq_imm",    32'(bus.ImmSrc), 32'd2);
      step();
      check("beq_s9",     32'(bus.state_o), 32'd9);
      check("beq_pcw",    32'(bus.PCWrite), 32'(z));
      check("beq_aluctl", 32'(bus.ALUControl), 32'd1);
      check("beq_ret",    32'(bus.instr_retired), 32'd1);
      step();
      check("beq_cycles", 32'(cyc - t0), 32'd3);
      check("beq_cnt",    bus.retired_cnt, 32'(5 - z));
    end
    bus.zero_flg = 1'b0;

    // jal: 0,1,10,8, single retire
    bus.instr = I_JAL;
    t0 = cyc;
    step();
    check("jal_imm",    32'(bus.ImmSrc), 32'd3);
    step();
    check("jal_s10",    32'(bus.state_o), 32'd10);
    check("jal_pcw",    32'(bus.PCWrite), 32'd1);
    check("jal_ret0",   32'(bus.instr_retired), 32'd0);
    check("jal_srca",   32'(bus.ALUSrcA), 32'd1);
    check("jal_srcb",   32'(bus.ALUSrcB), 32'd2);
    step();
    check("jal_s8",     32'(bus.state_o), 32'd8);
    check("jal_ret1",   32'(bus.instr_retired), 32'd1);
    step();
    check("jal_cycles", 32'(cyc - t0), 32'd4);
    check("jal_cnt",    bus.retired_cnt, 32'd6);

    // sw with ready: 4 cycles, retire in MEMWRITE
    bus.instr = I_SW;
    t0 = cyc;
    step();
    check("sw_imm",     32'(bus.ImmSrc), 32'd1);
    step();
    step();
    check("sw_s5",      32'(bus.state_o), 32'd5);
    check("sw_memw",    32'(bus.MemWrite), 32'd1);
    check("sw_adr",     32'(bus.AdrSrc), 32'd1);
    check("sw_ret",     32'(bus.instr_retired), 32'd1);
    step();
    check("sw_cycles",  32'(cyc - t0), 32'd4);
    check("sw_cnt",     bus.retired_cnt, 32'd7);

    // Illegal opcode
    bus.instr = I_ILL;
    step();
    step();
`ifdef MCU_ILLEGAL_TRAP_EN
    check("ill_s11",    32'(bus.state_o), 32'd11);
    check("ill_flag",   32'(bus.illegal_instr), 32'd1);
    check("ill_pcw",    32'(bus.PCWrite), 32'd0);
    step();
    check("ill_stay",   32'(bus.state_o), 32'd11);
`else
    check("ill_s0",     32'(bus.state_o), 32'd0);
`endif
    check("ill_cnt",    bus.retired_cnt, 32'd7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rst2_s0",    32'(bus.state_o), 32'd0);

    // Reset in the middle of a stalled MEMWRITE
    bus.instr = I_SW;
    step();
    step();
    bus.mem_ready = 1'b0;
    step();
    check("swr_s5",     32'(bus.state_o), 32'd5);
    check("swr_memw",   32'(bus.MemWrite), 32'd1);
    check("swr_ret0",   32'(bus.instr_retired), 32'd0);
    step();
    check("swr_hold",   32'(bus.state_o), 32'd5);
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    check("swr_rst_memw", 32'(bus.MemWrite), 32'd0);
    check("swr_rst_s0",   32'(bus.state_o), 32'd0);
    check("swr_rst_cnt",  bus.retired_cnt, 32'd0);
    check("swr_rst_irw",  32'(bus.IRWrite), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("post_s1",    32'(bus.state_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
